// File: rtl/vga_output_controller.sv
// VGA timing generator and DAC output stage: free-running pixel/line counters,
// sync/blank decode delayed to line up with the object-mux colour path.
module vga_output_controller #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0]             hcnt_r;
  logic [10:0]             vcnt_r;
  logic                    active_s;
  logic                    hsync_s;
  logic                    vsync_s;
  logic [2:0]              decode_s;
  logic [3*PIPE_DELAY-1:0] pipe_r;
  logic [3*PIPE_DELAY-1:0] pipe_next_s;
  logic [2:0]              delayed_s;

  // Horizontal and vertical position counters; vertical steps on line wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcnt_r <= 11'd0;
      vcnt_r <= 11'd0;
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= 11'd0;
      if (vcnt_r == V_LAST) begin
        vcnt_r <= 11'd0;
      end else begin
        vcnt_r <= vcnt_r + 11'd1;
      end
    end else begin
      hcnt_r <= hcnt_r + 11'd1;
    end
  end

  // Visible-area and sync-window decode straight from the counters.
  always_comb begin
    active_s = 1'b0;
    hsync_s  = 1'b0;
    vsync_s  = 1'b0;
    if ((hcnt_r < H_ACT_END) && (vcnt_r < V_ACT_END)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    if ((hcnt_r >= HS_START) && (hcnt_r < HS_END)) begin
      hsync_s = 1'b1;
    end else begin
      hsync_s = 1'b0;
    end
    if ((vcnt_r >= VS_START) && (vcnt_r < VS_END)) begin
      vsync_s = 1'b1;
    end else begin
      vsync_s = 1'b0;
    end
  end

  assign decode_s = {hsync_s, vsync_s, active_s};

  // Each pipeline stage carries {hsync, vsync, active}; newest stage in the low bits.
  generate
    if (PIPE_DELAY == 1) begin : g_pipe_one
      assign pipe_next_s = decode_s;
    end else begin : g_pipe_multi
      assign pipe_next_s = {pipe_r[3*PIPE_DELAY-4:0], decode_s};
    end
  endgenerate

  // Delay line matching the colour-path latency of the object mux.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pipe_r <= {(3*PIPE_DELAY){1'b0}};
    end else begin
      pipe_r <= pipe_next_s;
    end
  end

  assign delayed_s = pipe_r[3*PIPE_DELAY-1 -: 3];

  // DAC output registers; colour is forced to black outside the visible area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      oVGA_R       <= 8'h00;
      oVGA_G       <= 8'h00;
      oVGA_B       <= 8'h00;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
    end else begin
      if (delayed_s[0]) begin
        oVGA_R <= redIn;
        oVGA_G <= greenIn;
        oVGA_B <= blueIn;
      end else begin
        oVGA_R <= 8'h00;
        oVGA_G <= 8'h00;
        oVGA_B <= 8'h00;
      end
      oVGA_HS      <= ~delayed_s[2];
      oVGA_VS      <= ~delayed_s[1];
      oVGA_BLANK_N <= delayed_s[0];
    end
  end

  assign pixelX       = hcnt_r;
  assign pixelY       = vcnt_r;
  assign startOfFrame = (hcnt_r == 11'd0) && (vcnt_r == 11'd0);
  assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_output_controller.sv
// Directed bench: full-size timing on one instance, a short-frame instance for vertical checks.
module tb_vga_output_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  red_q = 8'h00;
  logic [7:0]  red_in, green_in, blue_in;

  logic [10:0] px, py, px_s, py_s;
  logic        sof, sof_s;
  logic [7:0]  r, g, b, r_s, g_s, b_s;
  logic        hs, vs, blank_n, sync_n, hs_s, vs_s, blank_n_s, sync_n_s;

  int n_vec = 0;
  int n_err = 0;
  int c = 0;

  always #5 clk = ~clk;

  // Object-mux model: one-cycle colour latency from pixelX.
  always @(posedge clk) red_q <= px[7:0];

  assign red_in   = mode ? 8'hAA : red_q;
  assign green_in = mode ? 8'hAA : 8'hFF;
  assign blue_in  = mode ? 8'hAA : 8'hFF;

  vga_output_controller dut (
    .clk(clk), .resetN(resetN),
    .redIn(red_in), .greenIn(green_in), .blueIn(blue_in),
    .pixelX(px), .pixelY(py), .startOfFrame(sof),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blank_n), .oVGA_SYNC_N(sync_n)
  );

  // Short frame: 6 visible lines, FP 2, sync lines 8..9, BP 3 -> 13 lines, 10400 cycles.
  vga_output_controller #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_s (
    .clk(clk), .resetN(resetN),
    .redIn(red_in), .greenIn(green_in), .blueIn(blue_in),
    .pixelX(px_s), .pixelY(py_s), .startOfFrame(sof_s),
    .oVGA_R(r_s), .oVGA_G(g_s), .oVGA_B(b_s),
    .oVGA_HS(hs_s), .oVGA_VS(vs_s), .oVGA_BLANK_N(blank_n_s), .oVGA_SYNC_N(sync_n_s)
  );

  task automatic step();
    @(negedge clk);
    c = c + 1;
  endtask

  task automatic restart();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    c = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    n_vec++; if (px !== 11'd0)    begin n_err++; $display("FAIL reset_px got %0d want 0", px); end
    n_vec++; if (py !== 11'd0)    begin n_err++; $display("FAIL reset_py got %0d want 0", py); end
    n_vec++; if (sof !== 1'b1)    begin n_err++; $display("FAIL reset_sof got %b want 1", sof); end
    n_vec++; if (hs !== 1'b1 || vs !== 1'b1) begin n_err++; $display("FAIL reset_sync got hs=%b vs=%b want 1/1", hs, vs); end
    n_vec++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL reset_blank got %b want 0", blank_n); end
    n_vec++; if ({r, g, b} !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %h want 000000", {r, g, b}); end
    n_vec++; if (sync_n !== 1'b0)  begin n_err++; $display("FAIL sync_n got %b want 0", sync_n); end
    @(negedge clk);
    n_vec++; if (px !== 11'd0 || sof !== 1'b1) begin n_err++; $display("FAIL reset_hold got px=%0d sof=%b want 0/1", px, sof); end
    resetN = 1'b1;
    c = 0;
  endtask

  task automatic test_first_pixel();
    step();
    n_vec++; if (px !== 11'd1 || py !== 11'd0) begin n_err++; $display("FAIL first_edge_pos got (%0d,%0d) want (1,0)", px, py); end
    n_vec++; if (sof !== 1'b0) begin n_err++; $display("FAIL first_edge_sof got %b want 0", sof); end
    n_vec++; if (blank_n !== 1'b0 || hs !== 1'b1) begin n_err++; $display("FAIL first_edge_out got blank=%b hs=%b want 0/1", blank_n, hs); end
    step();
    n_vec++; if (blank_n !== 1'b1 || r !== 8'h00 || g !== 8'hFF) begin n_err++; $display("FAIL pixel0 got blank=%b r=%h g=%h want 1/00/ff", blank_n, r, g); end
    step();
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL pixel1 got r=%h want 01", r); end
  endtask

  task automatic test_line();
    int ramp_bad = 0, first_hs = -1, hs_len = 0, blank_cnt = 0, px_max = 0, sof_cnt = 0;
    int h_out;
    logic [7:0] exp_r;
    restart();
    mode = 1'b0;
    while (c < 1601) begin
      step();
      h_out = (c - 2) % 800;
      exp_r = (c >= 2 && h_out < 640) ? h_out[7:0] : 8'h00;
      if (r !== exp_r || g !== ((c >= 2 && h_out < 640) ? 8'hFF : 8'h00)) ramp_bad++;
      if (c < 802 && hs === 1'b0) begin
        if (first_hs < 0) first_hs = c;
        hs_len++;
      end
      if (c >= 2 && c < 802 && blank_n === 1'b1) blank_cnt++;
      if (int'(px) > px_max) px_max = int'(px);
      if (sof === 1'b1) sof_cnt++;
      if (c == 800) begin
        n_vec++; if (px !== 11'd0 || py !== 11'd1) begin n_err++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", px, py); end
      end
    end
    n_vec++; if (ramp_bad !== 0)  begin n_err++; $display("FAIL ramp got %0d bad cycles want 0", ramp_bad); end
    n_vec++; if (first_hs !== 658) begin n_err++; $display("FAIL hs_start got %0d want 658", first_hs); end
    n_vec++; if (hs_len !== 96)   begin n_err++; $display("FAIL hs_len got %0d want 96", hs_len); end
    n_vec++; if (blank_cnt !== 640) begin n_err++; $display("FAIL blank_len got %0d want 640", blank_cnt); end
    n_vec++; if (px_max !== 799)  begin n_err++; $display("FAIL px_max got %0d want 799", px_max); end
    n_vec++; if (sof_cnt !== 0)   begin n_err++; $display("FAIL sof_in_line got %0d want 0", sof_cnt); end
  endtask

  task automatic test_const_color();
    int aa_blank = 0, aa_vis = 0;
    int v_out;
    restart();
    mode = 1'b1;
    while (c < 10401) begin
      step();
      if (c == 641) begin
        n_vec++; if ({r, g, b} !== 24'hAAAAAA) begin n_err++; $display("FAIL last_visible got %h want aaaaaa", {r, g, b}); end
      end
      if (c == 642) begin
        n_vec++; if ({r, g, b} !== 24'h000000) begin n_err++; $display("FAIL first_blank got %h want 000000", {r, g, b}); end
      end
      if (c >= 2) begin
        v_out = ((c - 2) / 800) % 13;
        if (v_out >= 6 && (r_s === 8'hAA || g_s === 8'hAA || b_s === 8'hAA)) aa_blank++;
        if (r_s === 8'hAA) aa_vis++;
      end
    end
    n_vec++; if (aa_blank !== 0)  begin n_err++; $display("FAIL aa_in_vblank got %0d want 0", aa_blank); end
    n_vec++; if (aa_vis !== 3840) begin n_err++; $display("FAIL aa_visible got %0d want 3840", aa_vis); end
    mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    restart();
    while (c < 1500) step();
    n_vec++; if (px !== 11'd700 || hs !== 1'b0) begin n_err++; $display("FAIL pre_abort got px=%0d hs=%b want 700/0", px, hs); end
    #2 resetN = 1'b0;
    #1;
    n_vec++; if (hs !== 1'b1) begin n_err++; $display("FAIL abort_hs got %b want 1", hs); end
    n_vec++; if ({r, g, b} !== 24'h0 || blank_n !== 1'b0) begin n_err++; $display("FAIL abort_dac got rgb=%h blank=%b want 0/0", {r, g, b}, blank_n); end
    n_vec++; if (px !== 11'd0 || py !== 11'd0) begin n_err++; $display("FAIL abort_pos got (%0d,%0d) want (0,0)", px, py); end
    @(negedge clk);
    resetN = 1'b1;
    c = 0;
  endtask

  task automatic test_frame();
    int first_hs = -1, hs_len = 0, first_vs = -1, vs_len = 0, blank_cnt = 0;
    int sof_cnt = 0, sof_first = -1, py_max = 0;
    while (c < 20801) begin
      step();
      if (c < 802 && hs === 1'b0) begin
        if (first_hs < 0) first_hs = c;
        hs_len++;
      end
      if (c < 10402 && vs_s === 1'b0) begin
        if (first_vs < 0) first_vs = c;
        vs_len++;
      end
      if (c >= 2 && c < 10402 && blank_n_s === 1'b1) blank_cnt++;
      if (sof_s === 1'b1) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = c;
      end
      if (int'(py_s) > py_max) py_max = int'(py_s);
    end
    n_vec++; if (first_hs !== 658 || hs_len !== 96) begin n_err++; $display("FAIL hs_after_abort got start=%0d len=%0d want 658/96", first_hs, hs_len); end
    n_vec++; if (first_vs !== 6402) begin n_err++; $display("FAIL vs_start got %0d want 6402", first_vs); end
    n_vec++; if (vs_len !== 1600)  begin n_err++; $display("FAIL vs_len got %0d want 1600", vs_len); end
    n_vec++; if (blank_cnt !== 3840) begin n_err++; $display("FAIL frame_blank got %0d want 3840", blank_cnt); end
    n_vec++; if (sof_cnt !== 2 || sof_first !== 10400) begin n_err++; $display("FAIL sof_period got cnt=%0d first=%0d want 2/10400", sof_cnt, sof_first); end
    n_vec++; if (py_max !== 12) begin n_err++; $display("FAIL py_max got %0d want 12", py_max); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line();
    test_const_color();
    test_mid_reset();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
